// File: rtl/inst_loader_if.sv
// Host-to-loader program stream: valid/ready word handshake with an end-of-program marker.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface inst_loader_if #(
    parameter int INST_WIDTH = `INST_WIDTH
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic [INST_WIDTH-1:0] s_data;
    logic                  s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/inst_loader.sv
// Buffers a host program, clears the instruction memory, replays the program as one
// gap-free inst_in_v burst, then waits for the memory to finish executing it.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 4
`endif

module inst_loader #(
    parameter int INST_WIDTH    = `INST_WIDTH,
    parameter int IM_ADDR_WIDTH = `IM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_loader_if.slave          host,
    output logic                  im_clr,
    output logic                  inst_in_v,
    output logic [INST_WIDTH-1:0] inst_in,
    input  logic                  inst_out_v,
    output logic                  busy,
    output logic                  err_overflow
);
    localparam int                 DEPTH   = 2 ** IM_ADDR_WIDTH;
    localparam logic [IM_ADDR_WIDTH:0] DEPTH_C = (IM_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IM_ADDR_WIDTH:0] ONE_C   = (IM_ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        LOAD,
        CLR,
        BURST,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IM_ADDR_WIDTH:0] cnt;
    logic [IM_ADDR_WIDTH:0] rp;
    logic                   s_ready_q;
    logic                   hs;
    logic                   full;
    logic                   burst_last;
    logic [INST_WIDTH-1:0]  mem [DEPTH];

    assign host.s_ready = s_ready_q;
    assign hs           = host.s_valid & s_ready_q;
    assign full         = (cnt == DEPTH_C);
    // rp has run ahead to cnt once the final word is already on inst_in.
    assign burst_last   = (rp == cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (hs && host.s_last) state_nxt = CLR;
            CLR:     state_nxt = BURST;
            BURST:   if (burst_last) state_nxt = WAIT_HI;
            WAIT_HI: if (inst_out_v) state_nxt = WAIT_LO;
            WAIT_LO: if (!inst_out_v) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // NOTE: the program buffer has no reset; its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (hs && !full) mem[cnt[IM_ADDR_WIDTH-1:0]] <= host.s_data;
    end

    // Outputs are registered from the next state so each one changes on the edge that enters its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            rp           <= '0;
            s_ready_q    <= 1'b0;
            im_clr       <= 1'b0;
            inst_in_v    <= 1'b0;
            inst_in      <= '0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            s_ready_q <= (state_nxt == LOAD);
            busy      <= (state_nxt != LOAD);
            im_clr    <= (state_nxt == CLR);
            inst_in_v <= (state_nxt == BURST);

            if (state == LOAD && hs) begin
                if (full) err_overflow <= 1'b1;
                else      cnt          <= cnt + ONE_C;
            end

            if (state == CLR) begin
                inst_in <= mem[0];
                rp      <= ONE_C;
            end

            if (state == BURST && !burst_last) begin
                inst_in <= mem[rp[IM_ADDR_WIDTH-1:0]];
                rp      <= rp + ONE_C;
            end

            if (state == WAIT_LO && !inst_out_v) cnt <= '0;
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: the driver queues expected bursts, a negedge monitor checks them.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 4
`endif

module tb_inst_loader;
    localparam int W     = `INST_WIDTH;
    localparam int AW    = `IM_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         im_clr;
    logic         inst_in_v;
    logic [W-1:0] inst_in;
    logic         inst_out_v = 1'b0;
    logic         busy;
    logic         err_overflow;

    inst_loader_if #(.INST_WIDTH(W)) host ();

    inst_loader #(.INST_WIDTH(W), .IM_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (host),
        .im_clr       (im_clr),
        .inst_in_v    (inst_in_v),
        .inst_in      (inst_in),
        .inst_out_v   (inst_out_v),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_word_q [$];
    int           exp_len_q  [$];
    int           compared   = 0;
    int           mismatched = 0;
    int           burst_len  = 0;
    int           bursts_done = 0;
    int           clr_count  = 0;
    bit           prev_v     = 0;
    bit           prev_clr   = 0;
    bit           err_exp    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word and every completed burst is matched against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (im_clr) clr_count++;
            if (inst_in_v) begin
                if (!prev_v) check("clr_before_burst", longint'(prev_clr), 1);
                if (exp_word_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", inst_in);
                end else begin
                    check("burst_word", longint'(inst_in), longint'(exp_word_q.pop_front()));
                end
                burst_len++;
            end else if (prev_v) begin
                if (exp_len_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_burst: got length %0d, expected no burst", burst_len);
                end else begin
                    check("burst_len", burst_len, exp_len_q.pop_front());
                end
                burst_len = 0;
                bursts_done++;
            end
            prev_v   = inst_in_v;
            prev_clr = im_clr;
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!host.s_ready) begin
            if (k++ > 400) begin
                mismatched++;
                $display("FAIL ready_timeout: s_ready=0, expected 1");
                $fatal(1, "s_ready never rose");
            end
            @(negedge clk);
        end
    endtask

    // Model: the burst is the first min(N, DEPTH) words; an over-long program sets a sticky error.
    task automatic load_program(input logic [W-1:0] prog [$], input bit gaps);
        int n = prog.size();
        for (int i = 0; i < n; i++) if (i < DEPTH) exp_word_q.push_back(prog[i]);
        exp_len_q.push_back((n < DEPTH) ? n : DEPTH);
        if (n > DEPTH) err_exp = 1;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    host.s_valid = 1'b0;
                end
            end
            @(negedge clk);
            host.s_valid = 1'b1;
            host.s_data  = prog[i];
            host.s_last  = (i == n - 1);
            wait_ready();
            @(posedge clk);
        end
        @(negedge clk);
        host.s_valid = 1'b0;
        host.s_last  = 1'b0;
    endtask

    task automatic run_program(input logic [W-1:0] prog [$], input bit gaps);
        int start = bursts_done;
        int clr0  = clr_count;
        int len   = (prog.size() < DEPTH) ? prog.size() : DEPTH;
        int k     = 0;
        load_program(prog, gaps);
        while (bursts_done == start) begin
            if (k++ > 4 * DEPTH + 50) begin
                mismatched++;
                $display("FAIL burst_timeout: bursts=%0d, expected %0d", bursts_done, start + 1);
                $fatal(1, "burst never completed");
            end
            @(negedge clk);
        end
        check("im_clr_pulses", clr_count - clr0, 1);
        repeat (16) @(negedge clk);
        check("wait_hi_busy", longint'(busy), 1);
        inst_out_v = 1'b1;
        repeat (len - 1) @(negedge clk);
        @(negedge clk);
        check("wait_lo_busy", longint'(busy), 1);
        inst_out_v = 1'b0;
        @(negedge clk);
        check("done_s_ready", longint'(host.s_ready), 1);
        check("done_busy", longint'(busy), 0);
        check("err_overflow", longint'(err_overflow), longint'(err_exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, longint'(host.s_ready), 0);
        check({tag, "_im_clr"}, longint'(im_clr), 0);
        check({tag, "_inst_in_v"}, longint'(inst_in_v), 0);
        check({tag, "_inst_in"}, longint'(inst_in), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_err"}, longint'(err_overflow), 0);
    endtask

    function automatic void rand_prog(output logic [W-1:0] q [$], input int n);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(W'($urandom()));
    endfunction

    initial begin
        logic [W-1:0] prog [$];
        int k;
        host.s_valid = 1'b0;
        host.s_data  = '0;
        host.s_last  = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("release_s_ready", longint'(host.s_ready), 1);
        check("release_busy", longint'(busy), 0);

        prog = {};
        for (int i = 0; i < 5; i++) prog.push_back(W'(32'h11 + i));
        run_program(prog, 0);

        prog = {};
        prog.push_back(W'(32'hAA));
        run_program(prog, 0);

        rand_prog(prog, 8);
        run_program(prog, 1);

        @(negedge clk);
        inst_out_v = 1'b1;
        @(negedge clk);
        inst_out_v = 1'b0;
        repeat (2) @(negedge clk);
        check("load_pulse_busy", longint'(busy), 0);
        check("load_pulse_s_ready", longint'(host.s_ready), 1);
        rand_prog(prog, 4);
        run_program(prog, 0);

        rand_prog(prog, DEPTH + 3);
        run_program(prog, 1);
        rand_prog(prog, 3);
        run_program(prog, 0);

        // Reset in the middle of an 8-word burst.
        rand_prog(prog, 8);
        load_program(prog, 0);
        k = 0;
        while (burst_len < 3) begin
            if (k++ > 100) begin
                mismatched++;
                $display("FAIL midburst_timeout: words=%0d, expected 3", burst_len);
                $fatal(1, "burst never started");
            end
            @(posedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midburst");
        exp_word_q.delete();
        exp_len_q.delete();
        burst_len = 0;
        prev_v    = 0;
        prev_clr  = 0;
        err_exp   = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rerelease_s_ready", longint'(host.s_ready), 1);
        rand_prog(prog, 2);
        run_program(prog, 0);

        repeat (4) @(negedge clk);
        check("sb_words_drained", exp_word_q.size(), 0);
        check("sb_bursts_drained", exp_len_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
